// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with double-buffered data,
// per-digit decimal point and blink, leading-zero blanking and PWM dimming.
module ssd_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int DIM_BITS     = 3,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic [DIM_BITS-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [7:0]              cathode,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]           r_presc;
   logic [IW-1:0]           r_idx;
   logic [FW-1:0]           r_frame;
   logic                    r_dark;
   logic [4*NUM_DIGITS-1:0] r_sh_data;
   logic [NUM_DIGITS-1:0]   r_sh_dp;
   logic [NUM_DIGITS-1:0]   r_sh_blink;
   logic [4*NUM_DIGITS-1:0] r_act_data;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_blink;
   logic                    r_pending;
   logic [NUM_DIGITS-1:0]   r_anode;
   logic [7:0]              r_cathode;
   logic                    r_frame_start;

   logic                    w_tc;
   logic                    w_last_digit;
   logic                    w_boundary;
   logic                    w_last_frame;
   logic [31:0]             w_on_window;
   logic                    w_lz_run;
   logic [NUM_DIGITS-1:0]   w_blank;
   logic [3:0]              w_cur_nib;
   logic                    w_cur_dp;
   logic                    w_cur_blink;
   logic                    w_cur_blank;
   logic                    w_visible;
   logic                    w_lit;
   logic [6:0]              w_seg;
   logic [NUM_DIGITS-1:0]   w_anode_nxt;
   logic [7:0]              w_cathode_nxt;

   // Active-low gfedcba font for hex digits 0-9, A, b, C, d, E, F.
   function automatic logic [6:0] seg_font(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   assign w_tc         = (r_presc == PW'(SCAN_DIV - 1));
   assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
   assign w_boundary   = w_tc && w_last_digit;
   assign w_last_frame = (r_frame == FW'(BLINK_FRAMES - 1));
   assign w_on_window  = (32'(brightness) + 32'd1) * (32'(SCAN_DIV) >> DIM_BITS);

   // Prescaler, digit index, frame counter and blink phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_frame <= '0;
         r_dark  <= 1'b0;
      end else begin
         if (w_tc) begin
            r_presc <= '0;
            if (w_last_digit) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + IW'(1);
            end
         end else begin
            r_presc <= r_presc + PW'(1);
         end
         if (w_boundary) begin
            if (w_last_frame) begin
               r_frame <= '0;
               r_dark  <= ~r_dark;
            end else begin
               r_frame <= r_frame + FW'(1);
            end
         end
      end
   end

   // Shadow/active double buffer; a coincident load lands in shadow after active copied it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh_data   <= '0;
         r_sh_dp     <= '0;
         r_sh_blink  <= '0;
         r_act_data  <= '0;
         r_act_dp    <= '0;
         r_act_blink <= '0;
         r_pending   <= 1'b0;
      end else begin
         if (w_boundary && r_pending) begin
            r_act_data  <= r_sh_data;
            r_act_dp    <= r_sh_dp;
            r_act_blink <= r_sh_blink;
         end
         if (load) begin
            r_sh_data  <= data_in;
            r_sh_dp    <= dp_in;
            r_sh_blink <= blink_mask;
            r_pending  <= 1'b1;
         end else if (w_boundary) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Leading-zero run from the most significant digit; digit 0 always shows.
   always_comb begin
      w_lz_run = blank_lz;
      w_blank  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (w_lz_run && (r_act_data[4*i +: 4] == 4'h0) && (i != 0)) begin
            w_blank[i] = 1'b1;
         end else begin
            w_blank[i] = 1'b0;
            w_lz_run   = 1'b0;
         end
      end
   end

   // Current-digit selection and next anode/cathode pattern.
   always_comb begin
      w_cur_nib   = 4'h0;
      w_cur_dp    = 1'b0;
      w_cur_blink = 1'b0;
      w_cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_cur_nib   = (r_idx == IW'(i)) ? r_act_data[4*i +: 4] : w_cur_nib;
         w_cur_dp    = (r_idx == IW'(i)) ? r_act_dp[i]          : w_cur_dp;
         w_cur_blink = (r_idx == IW'(i)) ? r_act_blink[i]       : w_cur_blink;
         w_cur_blank = (r_idx == IW'(i)) ? w_blank[i]           : w_cur_blank;
      end
      w_seg     = w_cur_blank ? 7'h7F : seg_font(w_cur_nib);
      w_visible = ~(w_cur_blink & r_dark) & (~w_cur_blank | w_cur_dp);
      w_lit     = w_visible && (32'(r_presc) < w_on_window);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_anode_nxt[i] = ~((r_idx == IW'(i)) & w_lit);
      end
      w_cathode_nxt = {~w_cur_dp, w_seg};
   end

   // Registered pin drivers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_anode       <= '1;
         r_cathode     <= 8'hFF;
         r_frame_start <= 1'b0;
      end else begin
         r_anode       <= w_anode_nxt;
         r_cathode     <= w_cathode_nxt;
         r_frame_start <= w_boundary;
      end
   end

   assign anode       = r_anode;
   assign cathode     = r_cathode;
   assign pending     = r_pending;
   assign frame_start = r_frame_start;

endmodule
